motor_ramp_ctrl: RTL and testbench
==================================

# motor_ramp_ctrl

Duty-cycle ramp scheduler that sits between the software/AXI register layer and the motor PWM generator. It accepts target-duty commands over a valid/ready handshake and drives the generator's duty register toward the target in bounded steps on a fixed tick. This gives soft start and soft stop. The block also enforces an emergency stop and a latched fault state, with optional stall detection driven by the encoder-derived motor speed.

## Interface
- DUTY_W, 32, width of duty, period and target values
- TICK_DIV, 100000, clk cycles per ramp tick (1 ms at 100 MHz)
- STALL_DUTY, 2000, minimum duty_out at which stall checking is armed
- STALL_TICKS, 500, consecutive zero-speed ticks that declare a stall
- clk  in  1  system clock; the only clock of the block
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  new target command present
- cmd_ready  out  1  command can be accepted
- cmd_target  in  DUTY_W  requested duty in clk counts
- cmd_step  in  16  duty increment per tick; 0 is treated as 1
- pwm_period  in  DUTY_W  current PWM period; targets are clamped to it
- estop  in  1  emergency stop, level-sensitive
- fault_clr  in  1  single-cycle pulse that clears a latched fault
- motor_speed  in  32  measured RPM; used only with stall detection
- duty_out  out  DUTY_W  duty value for the PWM generator
- duty_upd  out  1  one-cycle pulse whenever duty_out changes
- at_target  out  1  high while in HOLD
- busy  out  1  high in RAMP_UP or RAMP_DOWN
- fault  out  1  high in FAULT
- fault_code  out  2  00 none, 01 estop, 10 stall
- state_out  out  3  encoded current state, for debug

## Operation
- States: IDLE, RAMP_UP, RAMP_DOWN, HOLD, FAULT. Reset enters IDLE.
- cmd_ready = (state != FAULT) && !estop. It is registered-state based and deasserted during rst.
- On accept, the block latches target = min(cmd_target, pwm_period) and step = max(cmd_step, 1).
  - If target > duty_out, next state is RAMP_UP.
  - If target < duty_out, next state is RAMP_DOWN.
  - If target == duty_out, next state is HOLD.
- A new command is accepted in any non-FAULT state, including mid-ramp. The direction is re-evaluated from the current duty_out.
- On each tick in RAMP_UP: duty_out = (target − duty_out ≤ step) ? target : duty_out + step. RAMP_DOWN mirrors this (no underflow below target). Reaching the target moves the state to HOLD.
- HOLD and IDLE leave duty_out unchanged.
- estop high in any state:
  - duty_out is forced to 0 on the next edge.
  - state becomes FAULT and fault_code becomes 01.
  - estop wins over a simultaneous command; the command is not accepted.
- Leaving FAULT requires fault_clr && !estop. The block then goes to IDLE with fault_code = 00 and duty_out = 0. fault_clr is ignored while estop is high.
- pwm_period lowered below the latched target: the target is re-clamped on the next tick. If duty_out exceeds pwm_period, it is stepped down toward it.
- All arithmetic is unsigned DUTY_W-bit; differences are computed only in the non-negative direction.

## Timing
- Reset values: duty_out 0, duty_upd 0, at_target 0, busy 0, fault 0, fault_code 00, state_out IDLE, cmd_ready 0 during rst and 1 on the first cycle after.
- The tick counter is free-running 0..TICK_DIV−1 from reset. A tick is asserted for one cycle when the counter wraps.
- Command accepted at edge N: the state change is visible at N+1. The first duty step happens at the first tick after N.
- duty_out and duty_upd change on the same edge. duty_upd is never high without a change in duty_out.
- estop sampled at edge N: duty_out = 0 and fault = 1 from N+1, with no tick wait.
- Zero-distance command (target == duty_out): HOLD at N+1, no duty_upd.

## Configuration
- MOTOR_STALL_DETECT_EN defined:
  - A stall counter increments each tick while duty_out ≥ STALL_DUTY and motor_speed == 0. It clears otherwise.
  - Reaching STALL_TICKS sets FAULT with fault_code 10 and duty_out 0.
- Undefined: motor_speed is ignored, fault_code 10 is never produced, and no stall logic is synthesized.

## Structure
- Shared package motor_ctrl_pkg holds:
  - the state enum and its encoding: IDLE 0, RAMP_UP 1, RAMP_DOWN 2, HOLD 3, FAULT 4
  - the fault_code constants
  - the default DUTY_W
- Sub-module motor_tick_gen: a parameterized TICK_DIV counter with a single-cycle tick output, reusable by the speed-measurement logic.

## Test plan
- TICK_DIV=10, pwm_period=10000, command target 5000 step 1000 from 0 -> five duty_upd pulses 10 cycles apart, values 1000..5000, then at_target=1.
- Command target 4500 step 1000 from 0 -> final step is 4000→4500 (clamped), no overshoot; command target 20000 -> ramps to 10000 only.
- Mid-ramp at duty 3000 (ramping up to 5000), command target 1000 -> RAMP_DOWN, next values 2000, 1000, then HOLD.
- estop asserted at duty 3000 together with cmd_valid -> next cycle duty_out=0, fault=1, code 01, command not accepted. fault_clr while estop high -> no effect. After estop drops, fault_clr -> IDLE.
- cmd_step=0, target 3 -> steps of 1: values 1, 2, 3.
- With MOTOR_STALL_DETECT_EN, STALL_TICKS=3, duty 5000, motor_speed=0 -> FAULT, code 10, after the 3rd tick; a nonzero speed on tick 2 resets the count.

Source files
------------

// File: rtl/motor_ctrl_pkg.sv
// Shared definitions for the motor control blocks: FSM state encoding,
// fault code values and the default duty/period width.
package motor_ctrl_pkg;

    localparam int DUTY_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_RAMP_DOWN = 3'd2,
        ST_HOLD      = 3'd3,
        ST_FAULT     = 3'd4
    } motor_state_e;

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_ESTOP = 2'b01;
    localparam logic [1:0] FC_STALL = 2'b10;

endpackage

// File: rtl/motor_tick_gen.sv
// Free-running 0..TICK_DIV-1 counter. tick is high for the single cycle in
// which the counter sits at its top value, so the consumer acts on the same
// edge where the counter wraps back to 0.
module motor_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CNT_MAX);
    assign tick   = w_wrap;

    // Divider counter, restarts from 0 after reset and after each wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Duty-cycle ramp scheduler for the motor PWM generator. Accepts target
// commands (valid/ready), steps duty_out toward the target once per tick,
// and handles emergency stop and the latched fault state.
// Optional stall detection is built only when MOTOR_STALL_DETECT_EN is defined.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high; cmd_ready depends only on the registered state,
// estop and rst, never on cmd_valid.
module motor_ramp_ctrl
    import motor_ctrl_pkg::*;
#(
    parameter int          DUTY_W      = DUTY_W_DEF,
    parameter int          TICK_DIV    = 100000,
    parameter int unsigned STALL_DUTY  = 2000,
    parameter int unsigned STALL_TICKS = 500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DUTY_W-1:0] cmd_target,
    input  logic [15:0]       cmd_step,
    input  logic [DUTY_W-1:0] pwm_period,
    input  logic              estop,
    input  logic              fault_clr,
    input  logic [31:0]       motor_speed,
    output logic [DUTY_W-1:0] duty_out,
    output logic              duty_upd,
    output logic              at_target,
    output logic              busy,
    output logic              fault,
    output logic [1:0]        fault_code,
    output logic [2:0]        state_out
);

    motor_state_e      r_state, w_state_nxt;
    logic [DUTY_W-1:0] r_duty, w_duty_nxt;
    logic [DUTY_W-1:0] r_target, w_target_nxt;
    logic [DUTY_W-1:0] r_step, w_step_nxt;
    logic [1:0]        r_fcode, w_fcode_nxt;
    logic              r_upd, w_upd_nxt;

    logic              w_tick;
    logic              w_stall_trip;
    logic [DUTY_W-1:0] w_cmd_tgt, w_cmd_step;
    logic [DUTY_W-1:0] w_tick_tgt, w_dist, w_step_val;

    motor_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    // Incoming command: clamp target to the period, a zero step means 1.
    assign w_cmd_tgt  = (cmd_target > pwm_period) ? pwm_period : cmd_target;
    assign w_cmd_step = (cmd_step == 16'd0) ? DUTY_W'(1) : DUTY_W'(cmd_step);

    // Per-tick move: re-clamp the latched target, then take one bounded step
    // in whichever direction closes the gap; distance is always non-negative.
    assign w_tick_tgt = (r_target > pwm_period) ? pwm_period : r_target;
    assign w_dist     = (w_tick_tgt >= r_duty) ? (w_tick_tgt - r_duty) : (r_duty - w_tick_tgt);
    assign w_step_val = (w_dist <= r_step)     ? w_tick_tgt :
                        (w_tick_tgt > r_duty)  ? (r_duty + r_step) : (r_duty - r_step);

`ifdef MOTOR_STALL_DETECT_EN
    logic [31:0] r_stall_cnt, w_stall_cnt_nxt;
    logic        w_stall_cond;

    assign w_stall_cond = (r_duty >= DUTY_W'(STALL_DUTY)) && (motor_speed == 32'd0)
                          && (r_state != ST_FAULT);
    assign w_stall_trip = w_tick && w_stall_cond && ((r_stall_cnt + 32'd1) >= 32'(STALL_TICKS));

    // Stall count advances on each tick with the motor stopped under drive.
    always_comb begin
        w_stall_cnt_nxt = r_stall_cnt;
        if (!w_stall_cond || estop) begin
            w_stall_cnt_nxt = 32'd0;
        end else if (w_tick) begin
            w_stall_cnt_nxt = w_stall_trip ? 32'd0 : (r_stall_cnt + 32'd1);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
        end else begin
            r_stall_cnt <= w_stall_cnt_nxt;
        end
    end
`else
    logic w_unused_stall;
    assign w_unused_stall = ^{motor_speed, 32'(STALL_DUTY), 32'(STALL_TICKS)};
    assign w_stall_trip   = 1'b0;
`endif

    // Next-state and datapath: estop > fault hold > stall > command > tick.
    always_comb begin
        w_state_nxt  = r_state;
        w_duty_nxt   = r_duty;
        w_target_nxt = r_target;
        w_step_nxt   = r_step;
        w_fcode_nxt  = r_fcode;
        if (estop) begin
            w_state_nxt = ST_FAULT;
            w_duty_nxt  = '0;
            w_fcode_nxt = FC_ESTOP;
        end else if (r_state == ST_FAULT) begin
            if (fault_clr) begin
                w_state_nxt = ST_IDLE;
                w_duty_nxt  = '0;
                w_fcode_nxt = FC_NONE;
            end
        end else if (w_stall_trip) begin
            w_state_nxt = ST_FAULT;
            w_duty_nxt  = '0;
            w_fcode_nxt = FC_STALL;
        end else if (cmd_valid) begin
            w_target_nxt = w_cmd_tgt;
            w_step_nxt   = w_cmd_step;
            if (w_cmd_tgt > r_duty) begin
                w_state_nxt = ST_RAMP_UP;
            end else if (w_cmd_tgt < r_duty) begin
                w_state_nxt = ST_RAMP_DOWN;
            end else begin
                w_state_nxt = ST_HOLD;
            end
        end else if (w_tick && (r_state == ST_RAMP_UP || r_state == ST_RAMP_DOWN
                                || r_state == ST_HOLD)) begin
            w_target_nxt = w_tick_tgt;
            w_duty_nxt   = w_step_val;
            if (w_step_val == w_tick_tgt) begin
                w_state_nxt = ST_HOLD;
            end else if (w_tick_tgt > r_duty) begin
                w_state_nxt = ST_RAMP_UP;
            end else begin
                w_state_nxt = ST_RAMP_DOWN;
            end
        end
        w_upd_nxt = (w_duty_nxt != r_duty);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_duty   <= '0;
            r_target <= '0;
            r_step   <= DUTY_W'(1);
            r_fcode  <= FC_NONE;
            r_upd    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_duty   <= w_duty_nxt;
            r_target <= w_target_nxt;
            r_step   <= w_step_nxt;
            r_fcode  <= w_fcode_nxt;
            r_upd    <= w_upd_nxt;
        end
    end

    assign cmd_ready  = (r_state != ST_FAULT) && !estop && !rst;
    assign duty_out   = r_duty;
    assign duty_upd   = r_upd;
    assign at_target  = (r_state == ST_HOLD);
    assign busy       = (r_state == ST_RAMP_UP) || (r_state == ST_RAMP_DOWN);
    assign fault      = (r_state == ST_FAULT);
    assign fault_code = r_fcode;
    assign state_out  = r_state;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Bench for motor_ramp_ctrl: table of ramp commands plus hand-written
// sequences for mid-ramp retarget, estop/fault clear, period lowering and
// stall detection. Duty updates are checked against an expected queue.
module tb_motor_ramp_ctrl;
    import motor_ctrl_pkg::*;

    localparam int DW = 32;
    localparam int TD = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [DW-1:0] cmd_target;
    logic [15:0]   cmd_step;
    logic [DW-1:0] pwm_period;
    logic          estop;
    logic          fault_clr;
    logic [31:0]   motor_speed;
    logic [DW-1:0] duty_out;
    logic          duty_upd;
    logic          at_target;
    logic          busy;
    logic          fault;
    logic [1:0]    fault_code;
    logic [2:0]    state_out;

    motor_ramp_ctrl #(
        .DUTY_W(DW), .TICK_DIV(TD), .STALL_DUTY(2000), .STALL_TICKS(3)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_target(cmd_target), .cmd_step(cmd_step), .pwm_period(pwm_period),
        .estop(estop), .fault_clr(fault_clr), .motor_speed(motor_speed),
        .duty_out(duty_out), .duty_upd(duty_upd), .at_target(at_target),
        .busy(busy), .fault(fault), .fault_code(fault_code), .state_out(state_out)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_upd   = 0;
    int last_upd_cyc = 0;
    bit gap_chk = 1'b0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_duty = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // scoreboard: every duty_upd pops one expected duty value
    always @(negedge clk) begin
        if (rst === 1'b0 && duty_upd === 1'b1) begin
            n_upd++;
            if (gap_chk && n_upd > 1) check("upd_gap", cyc - last_upd_cyc, TD);
            last_upd_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_upd: got duty %0d, expected no update", duty_out);
            end else begin
                check("duty_seq", duty_out, exp_q.pop_front());
            end
        end
    end

    // expected duty sequence for one command starting from the modelled duty
    task automatic push_ramp(input logic [31:0] tgt_in, input logic [15:0] st_in);
        logic [31:0] t, s, d;
        t = (tgt_in > pwm_period) ? pwm_period : tgt_in;
        s = (st_in == 16'd0) ? 32'd1 : {16'd0, st_in};
        d = m_duty;
        while (d != t) begin
            if (d < t) d = ((t - d) <= s) ? t : d + s;
            else       d = ((d - t) <= s) ? t : d - s;
            exp_q.push_back(d);
        end
        m_duty = t;
    endtask

    // driver: one-cycle command, returns at the negedge after acceptance
    task automatic send_cmd(input logic [31:0] tgt, input logic [15:0] st, input bit push);
        int w = 0;
        while (cmd_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) check("cmd_ready_timeout", 32'(cmd_ready), 1);
        if (push) push_ramp(tgt, st);
        cmd_target = tgt;
        cmd_step   = st;
        cmd_valid  = 1'b1;
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_hold(input string name, input logic [31:0] exp_final);
        int w = 0;
        while (at_target !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (w >= 400) check({name, "_timeout"}, 32'(at_target), 1);
        #1;
        check({name, "_final"}, duty_out, exp_final);
        check({name, "_q_empty"}, exp_q.size(), 0);
    endtask

    task automatic wait_duty(input logic [31:0] val);
        int w = 0;
        while (duty_out !== val && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (w >= 400) check("wait_duty_timeout", duty_out, val);
        #1;
    endtask

    task automatic pulse_clr();
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
    endtask

    typedef struct {
        logic [31:0] target;
        logic [15:0] step;
        logic [31:0] exp_final;
        int          exp_upds;
        logic [2:0]  exp_state;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{32'd5000,  16'd1000,   32'd5000,  5, ST_RAMP_UP};
        vecs[1] = '{32'd0,     16'hFFFF,   32'd0,     1, ST_RAMP_DOWN};
        vecs[2] = '{32'd4500,  16'd1000,   32'd4500,  5, ST_RAMP_UP};
        vecs[3] = '{32'd20000, 16'd4000,   32'd10000, 2, ST_RAMP_UP};
        vecs[4] = '{32'd10000, 16'd7,      32'd10000, 0, ST_HOLD};
        vecs[5] = '{32'd0,     16'hFFFF,   32'd0,     1, ST_RAMP_DOWN};
        vecs[6] = '{32'd3,     16'd0,      32'd3,     3, ST_RAMP_UP};

        rst = 1'b1; cmd_valid = 1'b0; cmd_target = '0; cmd_step = '0;
        pwm_period = 32'd10000; estop = 1'b0; fault_clr = 1'b0; motor_speed = 32'd1500;
        repeat (3) @(negedge clk);
        check("rst_ready",   32'(cmd_ready), 0);
        check("rst_duty",    duty_out, 0);
        check("rst_upd",     32'(duty_upd), 0);
        check("rst_at_tgt",  32'(at_target), 0);
        check("rst_busy",    32'(busy), 0);
        check("rst_fault",   32'(fault), 0);
        check("rst_code",    32'(fault_code), 0);
        check("rst_state",   32'(state_out), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(cmd_ready), 1);

        // table-driven ramps
        for (int i = 0; i < 7; i++) begin
            n_upd   = 0;
            gap_chk = (i == 0);
            send_cmd(vecs[i].target, vecs[i].step, 1'b1);
            check($sformatf("vec%0d_state", i), 32'(state_out), 32'(vecs[i].exp_state));
            wait_hold($sformatf("vec%0d", i), vecs[i].exp_final);
            repeat (12) @(negedge clk);
            check($sformatf("vec%0d_upds", i), n_upd, vecs[i].exp_upds);
            check($sformatf("vec%0d_at_tgt", i), 32'(at_target), 1);
        end
        gap_chk = 1'b0;

        // mid-ramp retarget downward at duty 3000
        send_cmd(32'd0, 16'hFFFF, 1'b1);
        wait_hold("mid_zero", 0);
        send_cmd(32'd5000, 16'd1000, 1'b1);
        wait_duty(32'd3000);
        exp_q.delete();
        m_duty = 32'd3000;
        send_cmd(32'd1000, 16'd1000, 1'b1);
        check("mid_state", 32'(state_out), 32'(ST_RAMP_DOWN));
        check("mid_busy",  32'(busy), 1);
        wait_hold("mid", 1000);

        // estop with simultaneous command at duty 3000
        send_cmd(32'd5000, 16'd1000, 1'b1);
        wait_duty(32'd3000);
        exp_q.delete();
        exp_q.push_back(32'd0);
        m_duty = 32'd0;
        estop = 1'b1; cmd_target = 32'd8000; cmd_step = 16'd1000; cmd_valid = 1'b1;
        #1;
        check("estop_ready", 32'(cmd_ready), 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("estop_duty",  duty_out, 0);
        check("estop_fault", 32'(fault), 1);
        check("estop_code",  32'(fault_code), 1);
        check("estop_state", 32'(state_out), 32'(ST_FAULT));
        check("estop_busy",  32'(busy), 0);
        pulse_clr();
        check("clr_in_estop_fault", 32'(fault), 1);
        estop = 1'b0;
        @(negedge clk);
        check("fault_held",       32'(fault), 1);
        check("fault_ready",      32'(cmd_ready), 0);
        pulse_clr();
        check("clr_state", 32'(state_out), 32'(ST_IDLE));
        check("clr_fault", 32'(fault), 0);
        check("clr_code",  32'(fault_code), 0);
        check("clr_duty",  duty_out, 0);
        check("clr_ready", 32'(cmd_ready), 1);
        repeat (12) @(negedge clk);
        check("dropped_cmd_duty",  duty_out, 0);
        check("dropped_cmd_state", 32'(state_out), 32'(ST_IDLE));

        // lowering pwm_period below a held target steps duty down to it
        send_cmd(32'd8000, 16'd1000, 1'b1);
        wait_hold("per_up", 8000);
        exp_q.push_back(32'd7000);
        exp_q.push_back(32'd6000);
        exp_q.push_back(32'd5000);
        m_duty = 32'd5000;
        pwm_period = 32'd5000;
        wait_duty(32'd5000);
        check("per_at_tgt",  32'(at_target), 1);
        check("per_q_empty", exp_q.size(), 0);
        pwm_period = 32'd10000;

        // stall detection from a fresh step to 5000
        send_cmd(32'd0, 16'hFFFF, 1'b1);
        wait_hold("stall_zero", 0);
        send_cmd(32'd5000, 16'd5000, 1'b1);
        wait_hold("stall_up", 5000);
        motor_speed = 32'd0;
`ifdef MOTOR_STALL_DETECT_EN
        repeat (20) @(negedge clk);
        check("stall_tick2_fault", 32'(fault), 0);
        exp_q.push_back(32'd0);
        m_duty = 32'd0;
        repeat (10) @(negedge clk);
        check("stall_fault", 32'(fault), 1);
        check("stall_code",  32'(fault_code), 2);
        check("stall_duty",  duty_out, 0);
        motor_speed = 32'd1500;
        pulse_clr();
        check("stall_clr_state", 32'(state_out), 32'(ST_IDLE));
        send_cmd(32'd5000, 16'd5000, 1'b1);
        wait_hold("stall2_up", 5000);
        motor_speed = 32'd0;
        repeat (9) @(negedge clk);
        motor_speed = 32'd1;
        @(negedge clk);
        motor_speed = 32'd0;
        repeat (20) @(negedge clk);
        check("stall_reset_no_fault", 32'(fault), 0);
        exp_q.push_back(32'd0);
        m_duty = 32'd0;
        repeat (10) @(negedge clk);
        check("stall2_fault", 32'(fault), 1);
        check("stall2_code",  32'(fault_code), 2);
        motor_speed = 32'd1500;
        pulse_clr();
`else
        repeat (50) @(negedge clk);
        check("no_stall_fault", 32'(fault), 0);
        check("no_stall_code",  32'(fault_code), 0);
        check("no_stall_duty",  duty_out, 5000);
        motor_speed = 32'd1500;
`endif

        repeat (5) @(negedge clk);
        check("final_q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
